// File: rtl/int_to_fp.sv
// Multi-cycle converter from 64-bit two's-complement integer to IEEE-754 double,
// round-to-nearest-even, with valid/ready handshakes and one conversion in flight.
module int_to_fp (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [63:0] int_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [63:0] fp_out,
    output logic               out_inexact
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        sign;
    logic [63:0] mag;
    logic [5:0]  s;
    logic [2:0]  stage;
    logic [5:0]  amt;
    logic        top_zero;

    function automatic logic [5:0] stage_amt(input logic [2:0] k);
        return 6'd32 >> k;
    endfunction

    // Packs {inexact, sign, exponent, fraction}; a zero magnitude always yields +0.0.
    function automatic logic [64:0] round_pack(input logic sgn, input logic [63:0] m_in,
                                               input logic [5:0] sh);
        logic [52:0] mant;
        logic        g;
        logic        st;
        logic        up;
        logic [10:0] e;
        g    = m_in[10];
        st   = |m_in[9:0];
        up   = g && (st || m_in[11]);
        mant = {1'b0, m_in[62:11]} + {52'd0, up};
        e    = 11'd1086 - {5'd0, sh} + {10'd0, mant[52]};
        if (m_in == 64'd0)
            return 65'd0;
        return {g | st, sgn, e, mant[51:0]};
    endfunction

    assign amt      = stage_amt(stage);
    assign top_zero = (mag >> (7'd64 - {1'b0, amt})) == 64'd0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (stage == 3'd5)
                    state_nxt = ROUND;
            end
            ROUND: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, six binary-search normalization steps, then round.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fp_out      <= 64'd0;
            out_inexact <= 1'b0;
            stage       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign  <= int_in[63];
                        mag   <= int_in[63] ? 64'(-int_in) : 64'(int_in);
                        s     <= 6'd0;
                        stage <= 3'd0;
                    end
                end
                NORM: begin
                    if (top_zero) begin
                        mag <= mag << amt;
                        s   <= s + amt;
                    end
                    stage <= stage + 3'd1;
                end
                ROUND: {out_inexact, fp_out} <= round_pack(sign, mag, s);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp.sv
// Randomized self-checking bench for int_to_fp against an arithmetic rounding model.
module tb_int_to_fp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic        out_inexact;

    int n_checks = 0;
    int n_errors = 0;

    int_to_fp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .int_in     (int_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fp_out     (fp_out),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer -> nearest double, ties to even, from plain arithmetic.
    task automatic ref_conv(input logic [63:0] x, output logic [63:0] fp, output logic inx);
        logic        sgn;
        logic [63:0] m;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        int          p;
        int          r;
        sgn = x[63];
        m   = sgn ? (64'd0 - x) : x;
        fp  = 64'd0;
        inx = 1'b0;
        if (m != 64'd0) begin
            p = 0;
            for (int i = 0; i < 64; i++)
                if (m[i]) p = i;
            if (p <= 52) begin
                q = m << (52 - p);
            end else begin
                r    = p - 52;
                q    = m >> r;
                rem  = m & ((64'd1 << r) - 64'd1);
                half = 64'd1 << (r - 1);
                inx  = (rem != 64'd0);
                if (rem > half || (rem == half && q[0]))
                    q = q + 64'd1;
                if (q[53]) begin
                    q = q >> 1;
                    p = p + 1;
                end
            end
            fp = {sgn, 11'(1023 + p), q[51:0]};
        end
    endtask

    task automatic start(input logic [63:0] x);
        int n = 0;
        in_valid = 1'b1;
        int_in   = x;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready)
            check("accept_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        int_in   = {$urandom, $urandom};
    endtask

    task automatic wait_result(input logic [63:0] x, input string tag);
        logic [63:0] efp;
        logic        einx;
        int          cyc = 0;
        ref_conv(x, efp, einx);
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd7);
        check({tag, "_fp"}, fp_out, efp);
        check({tag, "_inexact"}, {63'd0, out_inexact}, {63'd0, einx});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_rise"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic convert(input logic [63:0] x, input string tag);
        start(x);
        wait_result(x, tag);
        release_out(tag);
    endtask

    logic [63:0] vec_in [10] = '{
        64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
        64'h1000000000000000, 64'hF000000000000000, 64'h8000000000000000,
        64'h0020000000000001, 64'h0020000000000003, 64'hFFDFFFFFFFFFFFFF,
        64'h7FFFFFFFFFFFFFFF
    };
    logic [63:0] vec_fp [10] = '{
        64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000,
        64'h43B0000000000000, 64'hC3B0000000000000, 64'hC3E0000000000000,
        64'h4340000000000000, 64'h4340000000000002, 64'hC340000000000000,
        64'h43E0000000000000
    };
    logic vec_inx [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [63:0] x;
        logic [63:0] efp;
        logic        einx;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        int_in    = 64'd5;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_fp_out", fp_out, 64'd0);
        check("rst_inexact", {63'd0, out_inexact}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed values with constant expectations.
        for (int i = 0; i < 10; i++) begin
            start(vec_in[i]);
            wait_result(vec_in[i], "vec");
            check("vec_const_fp", fp_out, vec_fp[i]);
            check("vec_const_inexact", {63'd0, out_inexact}, {63'd0, vec_inx[i]});
            release_out("vec");
        end

        // Backpressure: outputs held, requests ignored while the result waits.
        x = 64'h0020000000000003;
        start(x);
        wait_result(x, "bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            int_in   = {$urandom, $urandom};
            @(posedge clk); #1;
            check("bp_hold_fp", fp_out, 64'h4340000000000002);
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        release_out("bp");
        convert(64'hFFFFFFFFFFFF0000, "bp_next");

        // Reset during NORM stage 3 discards the work.
        start(64'h0000123456789ABC);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_fp_out", fp_out, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        start(64'h0000000000000002);
        wait_result(64'h0000000000000002, "post_rst");
        check("post_rst_const", fp_out, 64'h4000000000000000);
        release_out("post_rst");

        // Random operands of varied magnitude and sign.
        for (int i = 0; i < 200; i++) begin
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1)
                x = 64'd0 - x;
            start(x);
            wait_result(x, "rand");
            ref_conv(x, efp, einx);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("rand_ready_rise", {63'd0, in_ready}, 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/int_to_fp.md
# int_to_fp

Sequential converter from 64-bit signed integer (two's complement) to IEEE-754 double precision, rounding to nearest, ties-to-even. It is the inverse-direction companion to the `fp_to_int` converter and sits in the FPCalculator conversion path. It uses a valid/ready handshake on both sides and a fixed-latency multi-cycle normalizer, one conversion in flight.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  `int_in` holds a request
- `in_ready`  out  1  block idle and able to accept
- `int_in`  in  64  signed integer operand
- `out_valid`  out  1  `fp_out` / `out_inexact` valid
- `out_ready`  in  1  consumer accepts the result
- `fp_out`  out  64  double-precision result
- `out_inexact`  out  1  result differs from the exact integer value (guard or sticky bit set)

## Operation

- States: IDLE, NORM, ROUND, OUT.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`, latch the sign as `int_in[63]`.
  - Latch the magnitude as the 64-bit unsigned absolute value; `8000000000000000` gives magnitude 2^63.
  - Clear the shift count `s`, set stage counter to 0, go to NORM.
- NORM: exactly 6 cycles, stage k = 0..5 with shift amounts 32, 16, 8, 4, 2, 1.
  - If the top `amt` bits of the magnitude are all zero, shift the magnitude left by `amt` and add `amt` to `s`.
  - After stage 5, bit 63 is set unless the magnitude is 0. Go to ROUND.
- ROUND:
  - Mantissa `m = mag[62:11]`, guard `G = mag[10]`, sticky `S = |mag[9:0]`.
  - Round up when `G && (S || m[0])`.
  - Biased exponent `e = 1086 - s`, 11 bits.
  - On mantissa carry-out, `m = 0` and `e = e + 1`. The maximum is 1087, so no overflow or Inf is possible.
  - Zero magnitude: `fp_out = 64'h0` (+0.0, never -0.0) and `out_inexact = 0`.
  - Register `{sign, e, m}` into `fp_out` and `G|S` into `out_inexact`. Go to OUT.
- OUT:
  - `out_valid=1`; `fp_out` and `out_inexact` are held stable.
  - On `out_ready=1`, go to IDLE.
  - `in_ready=0`; no overlap with the next request.
- Input `int_in` is sampled only at the accept edge. Later changes are ignored.

## Timing

- Reset, with `rst_n` sampled low at a rising edge:
  - state = IDLE; `out_valid=0`, `fp_out=0`, `out_inexact=0`.
  - `in_ready` is a decode of state, so it reads 1. No accept occurs in any cycle where `rst_n=0`.
- Latency:
  - Accept edge E0; NORM occupies the edges E1–E6; ROUND registers the result at E7.
  - `out_valid` is high from the cycle after E7, a fixed 7 cycles after accept, for every input including 0.
- Output handshake:
  - The transfer completes on the edge where `out_valid && out_ready`.
  - `in_ready` rises the cycle after that transfer.
  - Minimum throughput is one conversion per 9 cycles.
- `out_ready` is held low: the block stays in OUT indefinitely with its outputs stable.
- `out_ready` high before `out_valid` has no effect.
- `in_valid` is ignored whenever `in_ready=0`; the requester must hold it until accepted.
- Reset mid-operation, in NORM, ROUND or OUT: abort, discard the partial result, and apply the reset values on the next edge.

## Test plan

- Basic values, each a separate request:
  - `0000000000000001` -> `3FF0000000000000`, inexact 0.
  - `FFFFFFFFFFFFFFFF` -> `BFF0000000000000`.
  - `0000000000000000` -> `0000000000000000`.
  - Each has `out_valid` exactly 7 cycles after accept.
- Large values:
  - `1000000000000000` (2^60) -> `43B0000000000000`.
  - `F000000000000000` (-2^60) -> `C3B0000000000000`.
  - `8000000000000000` -> `C3E0000000000000`, inexact 0.
- Ties-to-even:
  - `0020000000000001` (2^53+1) -> `4340000000000000`, inexact 1.
  - `0020000000000003` (2^53+3) -> `4340000000000002`, inexact 1.
  - `FFDFFFFFFFFFFFFF` (-(2^53+1)) -> `C340000000000000`.
- Carry into exponent: `7FFFFFFFFFFFFFFF` -> `43E0000000000000` (2^63), inexact 1.
- Backpressure:
  - Hold `out_ready=0` for 10 cycles after `out_valid`. `fp_out` must stay stable, and `in_ready=0` throughout even with `in_valid=1` and a changing `int_in`.
  - Then pulse `out_ready` for one cycle. `in_ready` must rise the next cycle and the new request must be accepted.
- Reset mid-operation:
  - Assert `rst_n=0` for one edge at NORM stage 3. Next cycle `out_valid=0`, `fp_out=0`, `in_ready=1`.
  - A following request `0000000000000002` -> `4000000000000000`.
